// File: rtl/carrier_nco_pkg.sv
// carrier_nco_pkg: shared address map and control-bit layout for the
// carrier NCO.
//   CNCO_SPACE     : value of addr[11:4] that selects this block
//   CNCO_*         : register offsets (addr[3:0]) within the block space
//   CTRL_*         : bit indices inside the control register
//   inCarrierSpace : block-space decode of a bus address
package carrier_nco_pkg;

   localparam logic [7:0] CNCO_SPACE  = 8'h10;

   localparam logic [3:0] CNCO_CENTER = 4'h0;
   localparam logic [3:0] CNCO_PHOFF  = 4'h4;
   localparam logic [3:0] CNCO_CTRL   = 4'h8;
   localparam logic [3:0] CNCO_FREQ   = 4'hC;

   localparam int CTRL_LOOP_EN = 0;
   localparam int CTRL_HOLD    = 1;
   localparam int CTRL_CLEAR   = 2;
   localparam int CTRL_FREEZE  = 3;

   function automatic logic inCarrierSpace(input logic [11:0] a);
      return a[11:4] == CNCO_SPACE;
   endfunction

endpackage

// File: rtl/carrier_nco_regs.sv
// carrierNcoRegs: microprocessor register file for the carrier NCO.
//   clk, reset        : system clock, async active-high reset
//   wr0..wr3          : byte-lane write strobes (wr0 = bits 7:0)
//   addr, din, dout   : bus address, write data, combinational read data
//   ncoFreq           : live frequency word for the read-only readback
//   centerFreq        : programmed centre frequency
//   phaseOffset       : output phase offset
//   loopEnable, holdOnUnlock, freezeAccum : control levels
//   clearPhase        : one-cycle pulse following a control write with bit2 set
module carrierNcoRegs
   import carrier_nco_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        wr0,
   input  logic        wr1,
   input  logic        wr2,
   input  logic        wr3,
   input  logic [11:0] addr,
   input  logic [31:0] din,
   input  logic [31:0] ncoFreq,
   output logic [31:0] dout,
   output logic [31:0] centerFreq,
   output logic [11:0] phaseOffset,
   output logic        loopEnable,
   output logic        holdOnUnlock,
   output logic        clearPhase,
   output logic        freezeAccum
);

   logic hit;
   assign hit = inCarrierSpace(addr);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         centerFreq   <= '0;
         phaseOffset  <= '0;
         loopEnable   <= 1'b0;
         holdOnUnlock <= 1'b0;
         clearPhase   <= 1'b0;
         freezeAccum  <= 1'b0;
      end else begin
         clearPhase <= 1'b0;
         if (hit) begin
            case (addr[3:0])
               CNCO_CENTER: begin
                  if (wr0) centerFreq[7:0]   <= din[7:0];
                  if (wr1) centerFreq[15:8]  <= din[15:8];
                  if (wr2) centerFreq[23:16] <= din[23:16];
                  if (wr3) centerFreq[31:24] <= din[31:24];
               end
               CNCO_PHOFF: begin
                  if (wr0) phaseOffset[7:0]  <= din[7:0];
                  if (wr1) phaseOffset[11:8] <= din[11:8];
               end
               CNCO_CTRL: begin
                  if (wr0) begin
                     loopEnable   <= din[CTRL_LOOP_EN];
                     holdOnUnlock <= din[CTRL_HOLD];
                     clearPhase   <= din[CTRL_CLEAR];
                     freezeAccum  <= din[CTRL_FREEZE];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      dout = '0;
      if (hit) begin
         case (addr[3:0])
            CNCO_CENTER: dout = centerFreq;
            CNCO_PHOFF:  dout = {20'd0, phaseOffset};
            CNCO_CTRL:   dout = {28'd0, freezeAccum, 1'b0, holdOnUnlock, loopEnable};
            CNCO_FREQ:   dout = ncoFreq;
            default:     dout = '0;
         endcase
      end
   end

endmodule

// File: rtl/carrier_nco.sv
// carrier_nco: carrier tracking loop NCO.
//   clk, reset          : system clock, async active-high reset
//   ddcSync             : sample strobe, accumulator advances when high
//   wr0..wr3/addr/din/dout : register bus
//   carrierFreqOffset   : loop lag frequency word (two's complement)
//   carrierLeadFreq     : loop lead frequency word (two's complement)
//   carrierFreqEn       : qualifies both loop words
//   carrierLock         : loop lock indication
//   ncoPhase/ncoPhaseEn : carrier phase and its one-cycle valid strobe
//   ncoFreq             : centre + loop frequency word
module carrier_nco
   import carrier_nco_pkg::*;
#(
   parameter int ACC_WIDTH   = 32,
   parameter int PHASE_WIDTH = 12
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ddcSync,
   input  logic                   wr0,
   input  logic                   wr1,
   input  logic                   wr2,
   input  logic                   wr3,
   input  logic [11:0]            addr,
   input  logic [31:0]            din,
   output logic [31:0]            dout,
   input  logic [ACC_WIDTH-1:0]   carrierFreqOffset,
   input  logic [ACC_WIDTH-1:0]   carrierLeadFreq,
   input  logic                   carrierFreqEn,
   input  logic                   carrierLock,
   output logic [PHASE_WIDTH-1:0] ncoPhase,
   output logic                   ncoPhaseEn,
   output logic [ACC_WIDTH-1:0]   ncoFreq
);

   logic [31:0]            centerFreq;
   logic [11:0]            phaseOffset;
   logic                   loopEnable;
   logic                   holdOnUnlock;
   logic                   clearPhase;
   logic                   freezeAccum;
   logic [ACC_WIDTH-1:0]   loopFreq;
   logic [ACC_WIDTH-1:0]   acc;
   logic                   syncD;

   carrierNcoRegs uRegs (
      .clk          (clk),
      .reset        (reset),
      .wr0          (wr0),
      .wr1          (wr1),
      .wr2          (wr2),
      .wr3          (wr3),
      .addr         (addr),
      .din          (din),
      .ncoFreq      (32'(ncoFreq)),
      .dout         (dout),
      .centerFreq   (centerFreq),
      .phaseOffset  (phaseOffset),
      .loopEnable   (loopEnable),
      .holdOnUnlock (holdOnUnlock),
      .clearPhase   (clearPhase),
      .freezeAccum  (freezeAccum)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         loopFreq   <= '0;
         ncoFreq    <= '0;
         acc        <= '0;
         syncD      <= 1'b0;
         ncoPhase   <= '0;
         ncoPhaseEn <= 1'b0;
      end else begin
         // An unlocked loop with hold enabled keeps its last good frequency.
         if (carrierFreqEn) begin
            if (!loopEnable)
               loopFreq <= '0;
            else if (!(holdOnUnlock && !carrierLock))
               loopFreq <= carrierFreqOffset + carrierLeadFreq;
         end

         ncoFreq <= ACC_WIDTH'(centerFreq) + loopFreq;

         if (clearPhase)
            acc <= '0;
         else if (ddcSync && !freezeAccum)
            acc <= acc + ncoFreq;

         // Phase is taken one cycle after the advance so it reflects the new acc.
         syncD      <= ddcSync;
         ncoPhaseEn <= syncD;
         if (syncD)
            ncoPhase <= acc[ACC_WIDTH-1 -: PHASE_WIDTH] + PHASE_WIDTH'(phaseOffset);
      end
   end

endmodule
